// File: rtl/random_number_generator.sv
`timescale 1ns/1ps
// random_number_generator
//   Galois LFSR that steps every clock, with an external seed XOR-mixed into
//   the low bits each cycle. Used by the game FSM to choose the next mole.
//   Optional build macro RNG_WHITEN_EN: random_num becomes the XOR-fold of
//   the whole state instead of its low OUT_WIDTH bits. The state update is
//   the same in both builds.
module random_number_generator #(
  parameter int unsigned               LFSR_WIDTH  = 16,
  parameter int unsigned               OUT_WIDTH   = 2,
  parameter logic [LFSR_WIDTH-1:0]     TAPS        = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0]     RESET_STATE = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OUT_WIDTH-1:0] seed,
  output logic [OUT_WIDTH-1:0] random_num
);

  logic [LFSR_WIDTH-1:0] s;
  logic [LFSR_WIDTH-1:0] g;
  logic [LFSR_WIDTH-1:0] m;
  logic [LFSR_WIDTH-1:0] s_next;

  // Next state: Galois step, mix in seed, then recover if the result is zero.
  always_comb begin
    g      = '0;
    m      = '0;
    s_next = RESET_STATE;
    g = {1'b0, s[LFSR_WIDTH-1:1]} ^ (s[0] ? TAPS : '0);
    m = g ^ LFSR_WIDTH'(seed);
    if (m == '0) begin
      s_next = RESET_STATE;
    end else begin
      s_next = m;
    end
  end

  // State register: asynchronous reset to RESET_STATE, advances every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s <= RESET_STATE;
    end else begin
      s <= s_next;
    end
  end

`ifdef RNG_WHITEN_EN
  localparam int unsigned NSLICE = (LFSR_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int unsigned PADW   = NSLICE * OUT_WIDTH;

  logic [PADW-1:0]      padded;
  logic [OUT_WIDTH-1:0] fold;

  assign padded = PADW'(s);

  // Output fold: XOR of every OUT_WIDTH-bit slice of the zero-padded state.
  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      fold = fold ^ padded[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign random_num = fold;
`else
  assign random_num = s[OUT_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_random_number_generator.sv
`timescale 1ns/1ps
// Self-checking bench for random_number_generator (default parameters).
// Reference model steps the LFSR with plain integer arithmetic.
module tb_random_number_generator;

  localparam logic [15:0] RST  = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset  = 1'b0;
  logic [1:0] seed   = 2'b00;
  logic [1:0] random_num;

  int checks = 0;
  int errors = 0;

  logic [15:0] ms;
  logic [15:0] tbl [4];

  random_number_generator #(
    .LFSR_WIDTH (16),
    .OUT_WIDTH  (2),
    .TAPS       (16'hB400),
    .RESET_STATE(16'hACE1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed      (seed),
    .random_num(random_num)
  );

  always #5 clk = clk_en ? ~clk : clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_next(input logic [15:0] s, input logic [1:0] sd);
    int unsigned v;
    v = 32'(s) / 2;
    if ((32'(s) % 2) == 1) v = v ^ 32'(TAPS);
    v = v ^ 32'(sd);
    if (v == 0) v = 32'(RST);
    return 16'(v);
  endfunction

  function automatic logic [1:0] model_out(input logic [15:0] s);
`ifdef RNG_WHITEN_EN
    int unsigned v;
    int unsigned acc;
    v   = 32'(s);
    acc = 0;
    while (v != 0) begin
      acc = acc ^ (v % 4);
      v   = v / 4;
    end
    return 2'(acc);
`else
    return 2'(32'(s) % 4);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply seed, take one edge, advance model, settle 1ns past the edge.
  task automatic step(input logic [1:0] sv);
    seed = sv;
    @(posedge clk);
    ms = model_next(ms, sv);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check(tag, 32'(random_num), 32'(model_out(RST)));
    ms = RST;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int period;
    int mism;
    int zeros;
    int hist [4];

    tbl[0] = 16'hE270; tbl[1] = 16'h7138; tbl[2] = 16'h389C; tbl[3] = 16'h1C4E;

    // Reset with clock stopped
    #1 reset = 1'b1;
    #1 check("reset_noclk", 32'(random_num), 32'(model_out(RST)));
    ms = RST;
    clk_en = 1'b1;
    @(negedge clk);
    check("reset_held", 32'(random_num), 32'(model_out(RST)));
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      step(2'b00);
      check($sformatf("seq%0d", i), 32'(random_num), 32'(model_out(tbl[i])));
    end

    // Seed mixing latency
    do_reset("reset_s2");
    step(2'b11);
    check("seed3_e273", 32'(random_num), 32'(model_out(16'hE273)));
    step(2'b00);
    check("seed0_c539", 32'(random_num), 32'(model_out(16'hC539)));

    // Full period with seed held at zero
    do_reset("reset_s3");
    period = 0;
    mism   = 0;
    for (int i = 1; i <= 65535; i++) begin
      step(2'b00);
      if (random_num !== model_out(ms)) mism++;
      if (ms == RST && period == 0) period = i;
    end
    check("period_mism", 32'(mism), 0);
    check("period_len", 32'(period), 32'd65535);

    // FSM loopback: seed = previous output
    do_reset("reset_s4");
    mism  = 0;
    zeros = 0;
    for (int k = 0; k < 4; k++) hist[k] = 0;
    for (int i = 0; i < 10000; i++) begin
      step(random_num);
      if (random_num !== model_out(ms)) mism++;
      if (ms == 16'h0000) zeros++;
      if (!$isunknown(random_num)) hist[random_num]++;
    end
    check("loop_mism", 32'(mism), 0);
    check("loop_zero", 32'(zeros), 0);
    for (int k = 0; k < 4; k++)
      check($sformatf("hist%0d_ge1500", k), 32'(hist[k] >= 1500), 1);

    // Random seeds
    do_reset("reset_s5");
    mism = 0;
    for (int i = 0; i < 2000; i++) begin
      step(2'($urandom));
      if (random_num !== model_out(ms)) mism++;
    end
    check("rand_mism", 32'(mism), 0);

    // Asynchronous reset pulse mid-cycle after 37 edges
    do_reset("reset_s6");
    for (int i = 0; i < 37; i++) step(2'($urandom));
    check("pre_async", 32'(random_num), 32'(model_out(ms)));
    #1 reset = 1'b1;
    #1 check("async_rst", 32'(random_num), 32'(model_out(RST)));
    ms = RST;
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(2'b00);
      check($sformatf("post_seq%0d", i), 32'(random_num), 32'(model_out(tbl[i])));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
